config_reg_bank: RTL

Parametrised configuration register bank that replaces hand-wired per-module config decoding. It sits behind the host-facing `write_config_i`/`read_config_i` ports and decodes AXI-Lite-sized writes into `NUM_REGS` independent, FIFO-buffered ready/valid config channels. It keeps a readable shadow copy of every register and tracks per-channel overflow. Downstream blocks (stream/mem config consumers) attach to the channel outputs.

---
 rtl/config_reg_bank_if.sv | 36 +++
 rtl/config_reg_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/config_reg_bank_if.sv
// Shared widths and host-side config buses
// for the configuration register bank.
package libstf;
  parameter int AXI_ADDR_BITS  = 32;
  parameter int AXIL_DATA_BITS = 64;
endpackage

interface write_config_i;
  import libstf::*;
  logic [AXI_ADDR_BITS-1:0]  addr;
  logic [AXIL_DATA_BITS-1:0] data;
  logic                      valid;

  modport m (output addr, data, valid);
  modport s (input  addr, data, valid);
endinterface

interface read_config_i;
  import libstf::*;
  logic [AXI_ADDR_BITS-1:0]  read_addr;
  logic                      read_valid;
  logic                      read_ready;
  logic [AXIL_DATA_BITS-1:0] resp_data;
  logic                      resp_error;
  logic                      resp_valid;
  logic                      resp_ready;

  modport m (
    output read_addr, read_valid, resp_ready,
    input  read_ready, resp_data, resp_error, resp_valid
  );
  modport s (
    input  read_addr, read_valid, resp_ready,
    output read_ready, resp_data, resp_error, resp_valid
  );
endinterface

// File: rtl/config_reg_bank.sv
// Config register bank: decoded host writes feed
// per-channel FIFOs, with shadow read-back and overflow.
module config_reg_bank
  import libstf::*;
#(
  parameter int NUM_REGS   = 4,
  parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  write_config_i.s wr,
  read_config_i.s  rd,
  output logic [NUM_REGS-1:0][AXIL_DATA_BITS-1:0] cfg_data,
  output logic [NUM_REGS-1:0] cfg_valid,
  input  logic [NUM_REGS-1:0] cfg_ready
);

  localparam int AW = AXI_ADDR_BITS;
  localparam int DW = AXIL_DATA_BITS;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] STAT = AW'(8 * NUM_REGS);
  localparam logic [AW-4:0] NREG = (AW-3)'(NUM_REGS);

  logic [AW-1:0] wr_off;
  logic [AW-1:0] rd_off;
  logic          wr_ok;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          rd_acc;
  logic          rd_hit;
  logic          rd_stat;

  logic [DW-1:0] mem [NUM_REGS][FIFO_DEPTH];
  logic [PW:0]   wptr [NUM_REGS];
  logic [PW:0]   rptr [NUM_REGS];

  logic [NUM_REGS-1:0] hit;
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] pop;
  logic [NUM_REGS-1:0] push;
  logic [NUM_REGS-1:0] ovf_set;
  logic [NUM_REGS-1:0] ovf;

  logic [NUM_REGS-1:0][DW-1:0] shadow;

  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_error;

  assign wr_off = wr.addr - BASE_ADDR;
  assign wr_ok  = wr.valid && (wr_off[2:0] == 3'd0)
               && (wr_off[AW-1:3] < NREG);
  assign wr_idx = wr_off[3 +: IW];

  assign rd_off  = rd.read_addr - BASE_ADDR;
  assign rd_hit  = (rd_off[2:0] == 3'd0)
                && (rd_off[AW-1:3] < NREG);
  assign rd_stat = (rd_off == STAT);
  assign rd_idx  = rd_off[3 +: IW];
  assign rd_acc  = rd.read_valid && !resp_valid;

  assign rd.read_ready = !resp_valid;
  assign rd.resp_valid = resp_valid;
  assign rd.resp_data  = resp_data;
  assign rd.resp_error = resp_error;

  // Per-channel hit decode, FIFO status and push/pop qualification
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i]  = wr_ok && (wr_idx == IW'(i));
      full[i] = (wptr[i][PW] != rptr[i][PW])
             && (wptr[i][PW-1:0] == rptr[i][PW-1:0]);
      cfg_valid[i] = (wptr[i] != rptr[i]);
      cfg_data[i]  = mem[i][rptr[i][PW-1:0]];
      pop[i]  = (wptr[i] != rptr[i]) && cfg_ready[i];
      push[i] = hit[i] && (!full[i] || pop[i]);
      ovf_set[i] = hit[i] && full[i] && !pop[i];
    end
  end

  // FIFO storage; contents are don't-care until a push lands
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (push[i]) begin
        mem[i][wptr[i][PW-1:0]] <= wr.data;
      end
    end
  end

  // FIFO pointers; extra MSB separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + (PW+1)'(1);
        if (pop[i])  rptr[i] <= rptr[i] + (PW+1)'(1);
      end
    end
  end

  // Shadow copy and sticky overflow; a new overflow beats a status clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      ovf    <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hit[i]) shadow[i] <= wr.data;
      end
      ovf <= ((rd_acc && rd_stat) ? '0 : ovf) | ovf_set;
    end
  end

  // Single-outstanding read response, held until handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else if (rd_acc) begin
      resp_valid <= 1'b1;
      unique case (1'b1)
        rd_hit: begin
          resp_data  <= shadow[rd_idx];
          resp_error <= 1'b0;
        end
        rd_stat: begin
          resp_data  <= DW'(ovf);
          resp_error <= 1'b0;
        end
        default: begin
          resp_data  <= '0;
          resp_error <= 1'b1;
        end
      endcase
    end else if (resp_valid && rd.resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
